mem_access_unit: RTL and testbench

Memory-stage load/store sequencer that sits between the execute stage and the data memory port. It accepts one memory operation per request (word-aligned address, 4-bit byte mask, unsigned flag, store data). It issues a handshaked request to a variable-latency data memory and aligns store data into byte lanes. For loads, it extracts, sign- or zero-extends, and returns the data, stalling the pipeline through `o_busy` while an access is outstanding.

---
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle between the execute stage, mem_access_unit and the data memory port.
// The slave modport is the unit's view; master is the pipeline/memory environment.
interface mem_access_unit_if;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [31:0] i_addr;
  logic [3:0]  i_mask;
  logic        i_unsigned;
  logic [31:0] i_store_data;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_load_data;
  logic        o_misaligned;
  logic        o_fault;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ready;
  logic        i_dmem_valid;
  logic [31:0] i_dmem_rdata;

  modport slave (
    input  i_valid, i_mem_read, i_mem_write, i_addr, i_mask, i_unsigned, i_store_data,
    input  i_dmem_ready, i_dmem_valid, i_dmem_rdata,
    output o_busy, o_done, o_load_data, o_misaligned, o_fault,
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata
  );

  modport master (
    output i_valid, i_mem_read, i_mem_write, i_addr, i_mask, i_unsigned, i_store_data,
    output i_dmem_ready, i_dmem_valid, i_dmem_rdata,
    input  o_busy, o_done, o_load_data, o_misaligned, o_fault,
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: issues one handshaked data-memory access per op.
// Define MEM_ACCESS_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that completes with o_fault.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            i_clk,
  input logic            i_rst_n,
  mem_access_unit_if.slave io_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic        r_unsigned;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_req;
  logic [31:0] r_loadData;
  logic        r_misaligned;

  logic        w_accept;
  logic        w_maskLegal;
  logic        w_complete;
  logic        w_timeout;
  logic        w_timeoutHit;
  logic [31:0] w_storeData;
  logic [31:0] w_rdata;
  logic [31:0] w_alignedWdata;
  logic [31:0] w_extracted;

  assign w_storeData = io_bus.i_store_data;
  assign w_rdata     = io_bus.i_dmem_rdata;

  // DONE accepts like IDLE so back-to-back ops can start on the edge that leaves DONE.
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && io_bus.i_valid &&
                    (io_bus.i_mem_read || io_bus.i_mem_write);

  always_comb begin
    w_maskLegal = 1'b0;
    case (io_bus.i_mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_maskLegal = 1'b1;
      default:                   w_maskLegal = 1'b0;
    endcase
  end

  always_comb begin
    w_alignedWdata = '0;
    case (io_bus.i_mask)
      4'b0001: w_alignedWdata = {24'h0, w_storeData[7:0]};
      4'b0010: w_alignedWdata = {16'h0, w_storeData[7:0], 8'h0};
      4'b0100: w_alignedWdata = {8'h0, w_storeData[7:0], 16'h0};
      4'b1000: w_alignedWdata = {w_storeData[7:0], 24'h0};
      4'b0011: w_alignedWdata = {16'h0, w_storeData[15:0]};
      4'b1100: w_alignedWdata = {w_storeData[15:0], 16'h0};
      4'b1111: w_alignedWdata = w_storeData;
      default: w_alignedWdata = '0;
    endcase
  end

  always_comb begin
    w_extracted = w_rdata;
    case (r_mask)
      4'b0001: w_extracted = {{24{~r_unsigned & w_rdata[7]}},  w_rdata[7:0]};
      4'b0010: w_extracted = {{24{~r_unsigned & w_rdata[15]}}, w_rdata[15:8]};
      4'b0100: w_extracted = {{24{~r_unsigned & w_rdata[23]}}, w_rdata[23:16]};
      4'b1000: w_extracted = {{24{~r_unsigned & w_rdata[31]}}, w_rdata[31:24]};
      4'b0011: w_extracted = {{16{~r_unsigned & w_rdata[15]}}, w_rdata[15:0]};
      4'b1100: w_extracted = {{16{~r_unsigned & w_rdata[31]}}, w_rdata[31:16]};
      default: w_extracted = w_rdata;
    endcase
  end

  assign w_complete   = ((r_state == S_REQ) && io_bus.i_dmem_ready && r_we) ||
                        ((r_state == S_WAIT) && io_bus.i_dmem_valid);
  assign w_timeoutHit = ((r_state == S_REQ) || (r_state == S_WAIT)) && w_timeout && !w_complete;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CountWidth-1:0] r_count;
  logic                  r_fault;

  assign w_timeout      = (r_count == CountWidth'(TIMEOUT_CYCLES - 1));
  assign io_bus.o_fault = r_fault;

  // Watchdog counts REQ+WAIT cycles; fault is rewritten only when an op completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_count <= r_count + 1'b1;
      end
      if ((w_accept && !w_maskLegal) || w_complete) begin
        r_fault <= 1'b0;
      end else if (w_timeoutHit) begin
        r_fault <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog the limit can never be reached.
  assign w_timeout      = (TIMEOUT_CYCLES < 0);
  assign io_bus.o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_mask       <= '0;
      r_unsigned   <= 1'b0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_req        <= 1'b0;
      r_loadData   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            r_addr     <= io_bus.i_addr & 32'hFFFF_FFFC;
            r_mask     <= io_bus.i_mask;
            r_unsigned <= io_bus.i_unsigned;
            r_we       <= io_bus.i_mem_write;
            r_wdata    <= w_alignedWdata;
            if (w_maskLegal) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state      <= S_DONE;
              r_loadData   <= '0;
              r_misaligned <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if ((io_bus.i_dmem_ready && r_we) || w_timeoutHit) begin
            r_req        <= 1'b0;
            r_state      <= S_DONE;
            r_loadData   <= '0;
            r_misaligned <= 1'b0;
          end else if (io_bus.i_dmem_ready) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_bus.i_dmem_valid) begin
            r_state      <= S_DONE;
            r_loadData   <= w_extracted;
            r_misaligned <= 1'b0;
          end else if (w_timeoutHit) begin
            r_state      <= S_DONE;
            r_loadData   <= '0;
            r_misaligned <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_bus.o_busy       = (r_state != S_IDLE);
  assign io_bus.o_done       = (r_state == S_DONE);
  assign io_bus.o_load_data  = r_loadData;
  assign io_bus.o_misaligned = r_misaligned;
  assign io_bus.o_dmem_req   = r_req;
  assign io_bus.o_dmem_we    = r_we;
  assign io_bus.o_dmem_addr  = r_addr;
  assign io_bus.o_dmem_be    = r_mask;
  assign io_bus.o_dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit; completions are checked against a scoreboard queue.
// Build with MEM_ACCESS_TIMEOUT_EN defined to also exercise the watchdog (limit 8).
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        uns;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          readyDelay;
    int          validDelay;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
    logic        expMis;
  } vecRec_t;

  typedef struct {
    logic [31:0] loadData;
    logic        mis;
    logic        fault;
  } expRec_t;

  expRec_t sbQueue[$];
  expRec_t popItem;
  vecRec_t vecs[17];
  vecRec_t tmpVec;

  mem_access_unit_if bus();

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
`else
  mem_access_unit dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  task automatic pushExpected(input logic [31:0] loadData, input logic mis, input logic fault);
    expRec_t e;
    e.loadData = loadData;
    e.mis      = mis;
    e.fault    = fault;
    sbQueue.push_back(e);
  endtask

  // Every completion pulse pops the oldest expectation and compares the result outputs.
  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      checkFlag("sb.pending", sbQueue.size() > 0, 1'b1);
      if (sbQueue.size() > 0) begin
        popItem = sbQueue.pop_front();
        checkOutput("sb.loadData", bus.o_load_data, popItem.loadData);
        checkFlag("sb.misaligned", bus.o_misaligned, popItem.mis);
        checkFlag("sb.fault", bus.o_fault, popItem.fault);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkFlag({tag, ".busy"}, bus.o_busy, 1'b0);
    checkFlag({tag, ".done"}, bus.o_done, 1'b0);
    checkOutput({tag, ".loadData"}, bus.o_load_data, 32'h0);
    checkFlag({tag, ".misaligned"}, bus.o_misaligned, 1'b0);
    checkFlag({tag, ".fault"}, bus.o_fault, 1'b0);
    checkFlag({tag, ".req"}, bus.o_dmem_req, 1'b0);
    checkFlag({tag, ".we"}, bus.o_dmem_we, 1'b0);
    checkOutput({tag, ".addr"}, bus.o_dmem_addr, 32'h0);
    checkOutput({tag, ".be"}, {28'h0, bus.o_dmem_be}, 32'h0);
    checkOutput({tag, ".wdata"}, bus.o_dmem_wdata, 32'h0);
  endtask

  task automatic applyStimulus(input vecRec_t v, input string tag);
    @(negedge clk);
    bus.i_valid      = 1'b1;
    bus.i_mem_read   = v.rd;
    bus.i_mem_write  = v.wr;
    bus.i_addr       = v.addr;
    bus.i_mask       = v.mask;
    bus.i_unsigned   = v.uns;
    bus.i_store_data = v.sdata;
    pushExpected(v.expLoad, v.expMis, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    checkFlag({tag, ".busyStart"}, bus.o_busy, 1'b1);
    if (v.expMis) begin
      checkFlag({tag, ".noReq"}, bus.o_dmem_req, 1'b0);
      checkFlag({tag, ".doneIllegal"}, bus.o_done, 1'b1);
    end else begin
      for (int c = 0; c <= v.readyDelay; c++) begin
        checkFlag({tag, ".req"}, bus.o_dmem_req, 1'b1);
        checkFlag({tag, ".reqBusy"}, bus.o_busy, 1'b1);
        checkFlag({tag, ".reqNoDone"}, bus.o_done, 1'b0);
        checkOutput({tag, ".addr"}, bus.o_dmem_addr, v.expAddr);
        checkOutput({tag, ".be"}, {28'h0, bus.o_dmem_be}, {28'h0, v.mask});
        checkFlag({tag, ".we"}, bus.o_dmem_we, v.wr);
        if (v.wr) checkOutput({tag, ".wdata"}, bus.o_dmem_wdata, v.expWdata);
        bus.i_dmem_valid = 1'b1;
        bus.i_dmem_rdata = 32'hBAD0_BAD0;
        bus.i_dmem_ready = (c == v.readyDelay);
        @(negedge clk);
      end
      bus.i_dmem_ready = 1'b0;
      bus.i_dmem_valid = 1'b0;
      checkFlag({tag, ".reqDropped"}, bus.o_dmem_req, 1'b0);
      if (!v.wr) begin
        for (int k = 1; k <= v.validDelay; k++) begin
          checkFlag({tag, ".waitNoDone"}, bus.o_done, 1'b0);
          checkFlag({tag, ".waitBusy"}, bus.o_busy, 1'b1);
          bus.i_dmem_valid = (k == v.validDelay);
          bus.i_dmem_rdata = (k == v.validDelay) ? v.rdata : 32'h5555_AAAA;
          @(negedge clk);
        end
        bus.i_dmem_valid = 1'b0;
      end
      checkFlag({tag, ".done"}, bus.o_done, 1'b1);
      checkFlag({tag, ".doneBusy"}, bus.o_busy, 1'b1);
    end
    @(negedge clk);
    checkFlag({tag, ".donePulse"}, bus.o_done, 1'b0);
    checkFlag({tag, ".idleBusy"}, bus.o_busy, 1'b0);
  endtask

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_mem_read   = 1'b0;
    bus.i_mem_write  = 1'b0;
    bus.i_addr       = '0;
    bus.i_mask       = '0;
    bus.i_unsigned   = 1'b0;
    bus.i_store_data = '0;
    bus.i_dmem_ready = 1'b0;
    bus.i_dmem_valid = 1'b0;
    bus.i_dmem_rdata = '0;

    //             rd    wr    addr          mask     uns   sdata         rdata         rdy val expAddr       expWdata      expLoad       mis
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 4'b0010, 1'b0, 32'hA5A5_A5A5, 32'h1234_80FF, 0, 1, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h1234_80FF, 0, 1, 32'h0000_0100, 32'h0,        32'h0000_0080, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0200, 4'b1100, 1'b0, 32'h0000_BEEF, 32'h0,         3, 0, 32'h0000_0200, 32'hBEEF_0000, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0300, 4'b0110, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0300, 32'h0,        32'h0,         1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0404, 4'b1111, 1'b0, 32'h0,         32'h8765_4321, 1, 2, 32'h0000_0404, 32'h0,        32'h8765_4321, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0408, 4'b1000, 1'b0, 32'h1234_56C3, 32'hFFFF_FFFF, 0, 0, 32'h0000_0408, 32'hC300_0000, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_050C, 4'b0011, 1'b0, 32'h0,         32'h0000_8001, 0, 1, 32'h0000_050C, 32'h0,        32'hFFFF_8001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0510, 4'b1100, 1'b1, 32'h0,         32'hF00D_1234, 2, 1, 32'h0000_0510, 32'h0,        32'h0000_F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0514, 4'b0100, 1'b0, 32'h0,         32'h007F_0000, 0, 3, 32'h0000_0514, 32'h0,        32'h0000_007F, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0518, 4'b0001, 1'b0, 32'h0,         32'hFFFF_FF01, 0, 1, 32'h0000_0518, 32'h0,        32'h0000_0001, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_051C, 4'b0000, 1'b0, 32'h1234_5678, 32'h0,         0, 0, 32'h0000_051C, 32'h0,        32'h0,         1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0520, 4'b0001, 1'b0, 32'hFFFF_FF5A, 32'h0,         1, 0, 32'h0000_0520, 32'h0000_005A, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0524, 4'b1110, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0524, 32'h0,        32'h0,         1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0203, 4'b1111, 1'b0, 32'hCAFE_F00D, 32'h0,         0, 0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0600, 4'b0011, 1'b0, 32'hAAAA_1357, 32'h0,         2, 0, 32'h0000_0600, 32'h0000_1357, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0604, 4'b0100, 1'b0, 32'h0000_0099, 32'h0,         0, 0, 32'h0000_0604, 32'h0099_0000, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0608, 4'b1000, 1'b0, 32'h0,         32'h80FF_FFFF, 1, 1, 32'h0000_0608, 32'h0,        32'hFFFF_FF80, 1'b0};

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] valid without read or write is ignored");
    bus.i_valid = 1'b1;
    bus.i_mask  = 4'b1111;
    @(negedge clk);
    bus.i_valid = 1'b0;
    checkFlag("noop.busy", bus.o_busy, 1'b0);
    checkFlag("noop.req", bus.o_dmem_req, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] back-to-back: store then load accepted in DONE");
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b1;
    bus.i_addr = 32'h40; bus.i_mask = 4'b0001; bus.i_unsigned = 1'b0; bus.i_store_data = 32'h11;
    pushExpected(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_dmem_ready = 1'b1;
    checkOutput("b2b.storeWdata", bus.o_dmem_wdata, 32'h0000_0011);
    @(negedge clk);
    bus.i_dmem_ready = 1'b0;
    checkFlag("b2b.storeDone", bus.o_done, 1'b1);
    bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
    bus.i_addr = 32'h44; bus.i_mask = 4'b1111;
    pushExpected(32'h0BAD_F00D, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_dmem_ready = 1'b1;
    checkFlag("b2b.loadReq", bus.o_dmem_req, 1'b1);
    checkOutput("b2b.loadAddr", bus.o_dmem_addr, 32'h44);
    checkFlag("b2b.loadWe", bus.o_dmem_we, 1'b0);
    @(negedge clk);
    bus.i_dmem_ready = 1'b0; bus.i_dmem_valid = 1'b1; bus.i_dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.i_dmem_valid = 1'b0;
    checkFlag("b2b.loadDone", bus.o_done, 1'b1);
    @(negedge clk);
    checkFlag("b2b.idle", bus.o_busy, 1'b0);

    $display("[TB] reset in the middle of WAIT");
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
    bus.i_addr = 32'h700; bus.i_mask = 4'b1111;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_dmem_ready = 1'b1;
    @(negedge clk);
    bus.i_dmem_ready = 1'b0;
    checkFlag("rstMid.busyBefore", bus.o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkAllZero("rstMid");
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_dmem_valid = 1'b1; bus.i_dmem_rdata = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      checkFlag("rstMid.noDone", bus.o_done, 1'b0);
      checkFlag("rstMid.idle", bus.o_busy, 1'b0);
    end
    bus.i_dmem_valid = 1'b0;
    tmpVec = '{1'b1, 1'b0, 32'h0000_0700, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'h0000_0700, 32'h0, 32'hDEAD_BEEF, 1'b0};
    applyStimulus(tmpVec, "afterRst");

`ifdef MEM_ACCESS_TIMEOUT_EN
    $display("[TB] watchdog: load with ready but no read data");
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
    bus.i_addr = 32'h800; bus.i_mask = 4'b1111;
    pushExpected(32'h0, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_dmem_ready = 1'b1;
    @(negedge clk);
    bus.i_dmem_ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      checkFlag("timeout.busy", bus.o_busy, 1'b1);
      checkFlag("timeout.noDone", bus.o_done, 1'b0);
      checkFlag("timeout.noReq", bus.o_dmem_req, 1'b0);
      @(negedge clk);
    end
    checkFlag("timeout.done", bus.o_done, 1'b1);
    checkFlag("timeout.fault", bus.o_fault, 1'b1);
    @(negedge clk);
    checkFlag("timeout.donePulse", bus.o_done, 1'b0);
    checkFlag("timeout.faultHeld", bus.o_fault, 1'b1);
    tmpVec = '{1'b1, 1'b0, 32'h0000_0804, 4'b0011, 1'b1, 32'h0, 32'h0000_9ABC, 0, 2, 32'h0000_0804, 32'h0, 32'h0000_9ABC, 1'b0};
    applyStimulus(tmpVec, "afterTimeout");
`else
    $display("[TB] long wait completes without a watchdog");
    tmpVec = '{1'b1, 1'b0, 32'h0000_0900, 4'b1111, 1'b0, 32'h0, 32'h00C0_FFEE, 0, 20, 32'h0000_0900, 32'h0, 32'h00C0_FFEE, 1'b0};
    applyStimulus(tmpVec, "longWait");
    checkFlag("longWait.fault", bus.o_fault, 1'b0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("sb.empty", sbQueue.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
